// File: rtl/kd_tree_pkg.sv
// Shared command codes and controller state encoding for the kd-tree root sequencer.
package kd_tree_pkg;

    localparam int CMD_W = 5;

    localparam logic [CMD_W-1:0] CMD_NOP       = 5'h00;
    localparam logic [CMD_W-1:0] CMD_RST       = 5'h1f;
    localparam logic [CMD_W-1:0] CMD_RST_DONE  = 5'h1e;
    localparam logic [CMD_W-1:0] CMD_FILL      = 5'h01;
    localparam logic [CMD_W-1:0] CMD_FILL_DONE = 5'h05;
    localparam logic [CMD_W-1:0] CMD_SORT      = 5'h14;
    localparam logic [CMD_W-1:0] CMD_SORT_DONE = 5'h15;
    localparam logic [CMD_W-1:0] CMD_POINT     = 5'h16;
    localparam logic [CMD_W-1:0] CMD_BEST      = 5'h18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_FILL,
        ST_SORT_START,
        ST_SORT_WAIT,
        ST_READY,
        ST_QUERY,
        ST_ERR
    } kd_state_e;

endpackage

// File: rtl/kd_tree_ctrl_if.sv
// Front-end streams, result port and root-node command/data bus of the kd-tree sequencer.
interface kd_tree_ctrl_if #(
    parameter int DIM   = 3,
    parameter int DIM_W = 8
);
    import kd_tree_pkg::*;

    localparam int CENTER_W = DIM * DIM_W;
    localparam int DATA_W   = 2 * CENTER_W;

    logic                start;
    logic                ctr_valid;
    logic [CENTER_W-1:0] ctr_data;
    logic                ctr_ready;
    logic                pt_valid;
    logic [CENTER_W-1:0] pt_data;
    logic                pt_ready;
    logic                best_valid;
    logic [CENTER_W-1:0] best_data;
    logic                best_ready;
    logic [CMD_W-1:0]    tree_cmd;
    logic [DATA_W-1:0]   tree_data;
    logic [CMD_W-1:0]    tree_cmd_in;
    logic [DATA_W-1:0]   tree_data_in;
    logic                busy;
    logic                built;
    logic                timeout_err;

    modport master (
        input  start, ctr_valid, ctr_data, pt_valid, pt_data, best_ready,
               tree_cmd_in, tree_data_in,
        output ctr_ready, pt_ready, best_valid, best_data, tree_cmd, tree_data,
               busy, built, timeout_err
    );

    modport slave (
        output start, ctr_valid, ctr_data, pt_valid, pt_data, best_ready,
               tree_cmd_in, tree_data_in,
        input  ctr_ready, pt_ready, best_valid, best_data, tree_cmd, tree_data,
               busy, built, timeout_err
    );

endinterface

// File: rtl/kd_tree_timer.sv
// Acknowledge watchdog: counts enabled cycles, restarted by clr, flags the last allowed cycle.
module kd_tree_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Asserted during the TIMEOUT-th enabled cycle so the error lands exactly TIMEOUT cycles in.
    assign expired = en && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/kd_tree_ctrl.sv
// Root-node sequencer: reset, center fill, sort, then point queries returning the best center.
// Optional KD_TREE_CTRL_STATS_EN adds build_cycles / query_count outputs.
module kd_tree_ctrl
    import kd_tree_pkg::*;
#(
    parameter int DIM       = 3,
    parameter int DIM_W     = 8,
    parameter int N_CENTERS = 7,
    parameter int TIMEOUT   = 1024
) (
    input  logic clk,
    input  logic reset,
    kd_tree_ctrl_if.master bus
`ifdef KD_TREE_CTRL_STATS_EN
    ,
    output logic [31:0] build_cycles,
    output logic [31:0] query_count
`endif
);
    localparam int CENTER_W = DIM * DIM_W;
    localparam int DATA_W   = 2 * CENTER_W;
    localparam int CNT_W    = $clog2(N_CENTERS + 1);

    kd_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CENTER_W-1:0] point_q, point_d, best_q, best_d;
    logic                best_vld_q, best_vld_d;
    logic                built_q, built_d, err_q, err_d;
    logic                ctr_hs, pt_hs, start_ok, tmo_en, tmo_exp;

    assign bus.ctr_ready = (state_q == ST_FILL) && (cnt_q < CNT_W'(N_CENTERS));
    assign bus.pt_ready  = (state_q == ST_READY) && (!best_vld_q || bus.best_ready);
    assign ctr_hs        = bus.ctr_valid && bus.ctr_ready;
    assign pt_hs         = bus.pt_valid && bus.pt_ready;
    assign start_ok      = bus.start &&
                           (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_ERR);

    assign tmo_en = (state_q == ST_RST) || (state_q == ST_SORT_WAIT) || (state_q == ST_QUERY) ||
                    ((state_q == ST_FILL) && (cnt_q == CNT_W'(N_CENTERS)));

    kd_tree_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_d != state_q),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        point_d    = point_q;
        best_d     = best_q;
        best_vld_d = best_vld_q && !bus.best_ready;
        built_d    = built_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RST;
            ST_RST: begin
                cnt_d = '0;
                if (bus.tree_cmd_in == CMD_RST_DONE) state_d = ST_FILL;
                else if (tmo_exp)                    state_d = ST_ERR;
            end
            ST_FILL: begin
                if (ctr_hs) cnt_d = cnt_q + 1'b1;
                if (bus.tree_cmd_in == CMD_FILL_DONE) state_d = ST_SORT_START;
                else if (tmo_exp)                     state_d = ST_ERR;
            end
            ST_SORT_START: state_d = ST_SORT_WAIT;
            ST_SORT_WAIT: begin
                if (bus.tree_cmd_in == CMD_SORT_DONE) begin
                    state_d = ST_READY;
                    built_d = 1'b1;
                end else if (tmo_exp) begin
                    state_d = ST_ERR;
                end
            end
            ST_READY: begin
                if (start_ok) begin
                    state_d = ST_RST;
                end else if (pt_hs) begin
                    point_d = bus.pt_data;
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                if (bus.tree_cmd_in == CMD_BEST) begin
                    best_d     = bus.tree_data_in[CENTER_W-1:0];
                    best_vld_d = 1'b1;
                    state_d    = ST_READY;
                end else if (tmo_exp) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: if (start_ok) state_d = ST_RST;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_RST && state_q != ST_RST) begin
            err_d   = 1'b0;
            built_d = 1'b0;
        end
        if (state_d == ST_ERR) begin
            err_d   = 1'b1;
            built_d = 1'b0;
        end

        // Command register follows the state being entered, so the bus lines up with state_q.
        cmd_d  = CMD_NOP;
        data_d = '0;
        case (state_d)
            ST_RST:        cmd_d = CMD_RST;
            ST_SORT_START: cmd_d = CMD_SORT;
            ST_QUERY: begin
                cmd_d  = CMD_POINT;
                data_d = {{CENTER_W{1'b0}}, point_d};
            end
            ST_FILL: begin
                if (ctr_hs) begin
                    cmd_d  = CMD_FILL;
                    data_d = {{CENTER_W{1'b0}}, bus.ctr_data};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= CMD_NOP;
            data_q     <= '0;
            point_q    <= '0;
            best_q     <= '0;
            best_vld_q <= 1'b0;
            built_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            point_q    <= point_d;
            best_q     <= best_d;
            best_vld_q <= best_vld_d;
            built_q    <= built_d;
            err_q      <= err_d;
        end
    end

    assign bus.tree_cmd    = cmd_q;
    assign bus.tree_data   = data_q;
    assign bus.best_valid  = best_vld_q;
    assign bus.best_data   = best_q;
    assign bus.built       = built_q;
    assign bus.timeout_err = err_q;
    assign bus.busy        = (state_q == ST_RST) || (state_q == ST_FILL) ||
                             (state_q == ST_SORT_START) || (state_q == ST_SORT_WAIT) ||
                             (state_q == ST_QUERY);

`ifdef KD_TREE_CTRL_STATS_EN
    logic [31:0] bc_q, bc_lat_q, qc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bc_q     <= '0;
            bc_lat_q <= '0;
            qc_q     <= '0;
        end else begin
            if (start_ok)
                bc_q <= 32'd0;
            else if (state_q == ST_RST || state_q == ST_FILL ||
                     state_q == ST_SORT_START || state_q == ST_SORT_WAIT)
                bc_q <= bc_q + 32'd1;
            if (state_q == ST_SORT_WAIT && state_d == ST_READY) bc_lat_q <= bc_q + 32'd1;
            if (state_q == ST_QUERY && state_d == ST_READY)     qc_q <= qc_q + 32'd1;
        end
    end

    assign build_cycles = bc_lat_q;
    assign query_count  = qc_q;
`endif

endmodule

// File: doc/kd_tree_ctrl.md
Name: kd_tree_ctrl

Overview:
- Synthesizable sequencer that drives the root node of a kd-tree node array through its top command/data port.
- Runs the build flow (tree reset, center fill, sort) and then serves a stream of point queries, returning the best center for each.
- Replaces hand-written bench sequencing; generalised over center count, dimension count, component width and response timeout.
- Sits between the pixel/center streaming front end and the root node.

Parameters:
DIM, 3, components per point/center
DIM_W, 8, bits per component
CENTER_W, DIM*DIM_W, packed point/center width (derived)
DATA_W, 2*CENTER_W, node data bus width (derived)
CMD_W, 5, node command width
N_CENTERS, 7, centers loaded per build (= node count)
TIMEOUT, 1024, max cycles waiting for any tree acknowledge

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin a build (honoured only in IDLE, READY or ERR)
ctr_valid  in  1  center stream valid
ctr_data  in  CENTER_W  center value
ctr_ready  out  1  center accepted when valid&ready
pt_valid  in  1  query point valid
pt_data  in  CENTER_W  query point
pt_ready  out  1  point accepted when valid&ready
best_valid  out  1  result valid, held until best_ready
best_data  out  CENTER_W  best center for the last query
best_ready  in  1  result consumed
tree_cmd  out  CMD_W  to root command_from_top
tree_data  out  DATA_W  to root data_from_top
tree_cmd_in  in  CMD_W  from root command_to_top
tree_data_in  in  DATA_W  from root data_to_top
busy  out  1  high in RST, FILL, SORT_START, SORT_WAIT, QUERY
built  out  1  tree sorted and query-capable
timeout_err  out  1  sticky error flag

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `reset`. Reset wins over every other input in the same cycle.
- Reset values:
  - all outputs 0
  - tree_cmd = nop (5'h00), tree_data = 0
  - state IDLE, center counter 0, timeout counter 0
- Output timing: tree_cmd and tree_data are registered; a handshake in cycle N drives the command in cycle N+1.
- Command codes (fixed): nop 00, rst 1f, rst_done 1e, center_fill 01, center_fill_done 05, start_sorting_as_root 14, sort_done 15, point_in_as_root 16, return_best 18.
- IDLE: tree_cmd = nop. On start → RST.
- RST: drive rst every cycle until tree_cmd_in == rst_done → FILL; clear center counter.
- FILL:
  - ctr_ready = (count < N_CENTERS).
  - On handshake: tree_cmd = center_fill, tree_data = {CENTER_W zeros, ctr_data}, count++.
  - No handshake: tree_cmd = nop.
  - tree_cmd_in == center_fill_done → SORT_START, regardless of count.
- SORT_START: drive start_sorting_as_root, tree_data = 0, for one cycle → SORT_WAIT.
- SORT_WAIT: drive nop until sort_done → READY; built set to 1.
- READY:
  - pt_ready = 1 (forced 0 if best_valid is still pending).
  - On handshake: latch the point → QUERY.
  - start → RST; built cleared.
- QUERY:
  - Drive point_in_as_root with {zeros, point} every cycle.
  - On tree_cmd_in == return_best: best_data = tree_data_in[CENTER_W-1:0], best_valid = 1, tree_cmd = nop, → READY.
- Result hold: best_valid stays high with best_data stable until best_ready; it clears in the same cycle it is consumed. A new point is accepted only once best_valid is 0 or being consumed in that cycle.
- Timeout:
  - Counter is active in RST, SORT_WAIT, QUERY, and in FILL once count == N_CENTERS. It restarts on each state entry.
  - Reaching TIMEOUT → ERR: timeout_err = 1, tree_cmd = nop, built = 0.
  - ERR exits only via start → RST; timeout_err clears on entering RST.
- Ignored inputs: start in RST, FILL, SORT_START, SORT_WAIT or QUERY is ignored. Unexpected tree_cmd_in codes are ignored.
- Counter widths: counter is $clog2(N_CENTERS+1) bits; timeout counter is $clog2(TIMEOUT+1) bits. No wrap is possible.

Optional Feature:
- Macro KD_TREE_CTRL_STATS_EN.
- Defined: adds outputs build_cycles (32 b, cycles from leaving IDLE/READY/ERR on start to reaching READY, latched on entry to READY) and query_count (32 b, completed queries, wrapping). Both reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package kd_tree_pkg: command localparams (nop…return_best), CMD_W, controller state encoding, pack/unpack helper for {zeros, point}.
- No sub-module needed; an optional timeout counter sub-module, kd_tree_timer, is natural and reused per state.

Test Plan:
1. Reset mid-QUERY with tree_cmd = 16 → next cycle tree_cmd = 00, best_valid = 0, built = 0, state IDLE.
2. start; model answers rst_done after 3 cycles; stream 7 centers; then center_fill_done; sort_done 5 cycles after 14 → exactly 7 center_fill commands seen, one 14 pulse, built = 1.
3. pt_data = 0x0A000A; model returns return_best with tree_data_in low = 0x0C0109 after 4 cycles → best_valid = 1, best_data = 0x0C0109; tree_cmd = 16 held all 4 cycles.
4. best_ready held low 10 cycles with pt_valid = 1 → pt_ready = 0 throughout, best_data stable; raise best_ready → next point is accepted.
5. Model never sends sort_done, TIMEOUT = 16 → timeout_err = 1 exactly 16 cycles after entering SORT_WAIT; start then re-enters RST and clears timeout_err.
6. ctr_valid gaps (valid every 3rd cycle) → tree_cmd alternates 01/00 correctly; an 8th center is never accepted.
